// File: rtl/seq_pkg.sv
// Shared encodings for the accumulator sequencer: FSM states, opcode classes,
// instruction field positions and flag bit indices.
package seq_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [3:0] OP_BRANCH = 4'hF;
    localparam logic [3:0] OP_HALT   = 4'hE;
    localparam logic [3:0] OP_NOP    = 4'h0;

    localparam int OP_CLASS_HI = 15;
    localparam int OP_CLASS_LO = 12;

    localparam int WSEL_A   = 11;
    localparam int WSEL_B   = 10;
    localparam int WSEL_ZNC = 9;

    localparam int BR_MASK_HI = 11;
    localparam int BR_MASK_LO = 9;
    localparam int BR_OFF_HI  = 7;
    localparam int BR_OFF_LO  = 0;

    localparam int ZNC_Z = 2;
    localparam int ZNC_N = 1;
    localparam int ZNC_C = 0;

    // Anything that is not a branch, halt or the all-zero NOP drives the ALU.
    function automatic logic is_alu_op(input logic [15:0] op);
        logic [3:0] op_class;
        op_class = op[OP_CLASS_HI:OP_CLASS_LO];
        return !((op_class == OP_BRANCH) || (op_class == OP_HALT) ||
                 ((op_class == OP_NOP) && (op[11:0] == 12'h000)));
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational next-PC resolution: branch condition against the flag register
// and PC-relative target with modulo-2^ADDR_W arithmetic.
module branch_unit
    import seq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       opCode,
    input  logic [2:0]        znc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken
);

    logic [2:0]        mask;
    logic [7:0]        offset;
    logic [ADDR_W-1:0] offset_ext;
    logic [ADDR_W-1:0] pc_inc;
    logic              flag_hit;
    logic              is_branch;
    logic              unused_bit;

    assign mask       = opCode[BR_MASK_HI:BR_MASK_LO];
    assign offset     = opCode[BR_OFF_HI:BR_OFF_LO];
    assign unused_bit = opCode[8];
    assign offset_ext = ADDR_W'(signed'(offset));
    assign is_branch  = (opCode[OP_CLASS_HI:OP_CLASS_LO] == OP_BRANCH);

    // An empty mask is the unconditional form; otherwise any selected flag set wins.
    assign flag_hit = (mask[ZNC_Z] & znc[ZNC_Z]) |
                      (mask[ZNC_N] & znc[ZNC_N]) |
                      (mask[ZNC_C] & znc[ZNC_C]);
    assign taken    = is_branch && ((mask == 3'b000) || flag_hit);

    assign pc_inc  = pc + ADDR_W'(1);
    assign next_pc = taken ? (pc_inc + offset_ext) : pc_inc;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch over req/ack, one-cycle execute with
// single-pulse register enables, branch resolution and halt.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic [2:0]        znc,
    output logic [15:0]       opCode,
    output logic              a_en,
    output logic              b_en,
    output logic              znc_en,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] next_pc;
    logic              branch_taken_unused;
    logic              exec_alu;

    branch_unit #(.ADDR_W(ADDR_W)) u_branch (
        .pc      (pc),
        .opCode  (opCode),
        .znc     (znc),
        .next_pc (next_pc),
        .taken   (branch_taken_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= START_PC;
            opCode <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= START_PC;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        opCode <= imem_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (opCode[OP_CLASS_HI:OP_CLASS_LO] == OP_HALT) begin
                        state <= HALT;
                    end else begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    if (start) begin
                        pc    <= START_PC;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request and enables decode straight from state, so reset drops them at once.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == EXEC);
    assign halted    = (state == HALT);

    assign exec_alu = (state == EXEC) && is_alu_op(opCode);
    assign a_en     = exec_alu && opCode[WSEL_A];
    assign b_en     = exec_alu && opCode[WSEL_B];
    assign znc_en   = exec_alu && opCode[WSEL_ZNC];

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl: fetch handshake, wait states,
// branches, PC wrap, halt/restart and reset during a fetch.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [2:0]  znc;
    logic [15:0] opCode;
    logic        a_en;
    logic        b_en;
    logic        znc_en;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_op;

    seq_ctrl #(.ADDR_W(8), .START_PC(8'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .znc       (znc),
        .opCode    (opCode),
        .a_en      (a_en),
        .b_en      (b_en),
        .znc_en    (znc_en),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after EXEC.
    task automatic applyStimulus(input logic [15:0] data, input int waits,
                                 input logic [7:0] addr, input logic [2:0] en,
                                 input logic [7:0] pc_after);
        for (int i = 0; i < waits; i++) begin
            checkOutput("wait_req", imem_req, 1);
            checkOutput("wait_addr", imem_addr, addr);
            checkOutput("wait_op", opCode, exp_op);
            checkOutput("wait_en", {a_en, b_en, znc_en}, 3'b000);
            imem_data = 16'($urandom);
            @(negedge clk);
        end
        checkOutput("fetch_req", imem_req, 1);
        checkOutput("fetch_addr", imem_addr, addr);
        imem_ack  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        exp_op    = data;
        checkOutput("exec_op", opCode, data);
        checkOutput("exec_req", imem_req, 0);
        checkOutput("exec_busy", busy, 1);
        checkOutput("exec_en", {a_en, b_en, znc_en}, en);
        @(negedge clk);
        checkOutput("post_pc", pc, pc_after);
        checkOutput("post_en", {a_en, b_en, znc_en}, 3'b000);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        znc       = 3'b000;
        exp_op    = 16'h0000;

        @(negedge clk);
        checkOutput("rst_pc", pc, 8'd0);
        checkOutput("rst_op", opCode, 16'h0000);
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_en", {a_en, b_en, znc_en}, 3'b000);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_halted", halted, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req", imem_req, 0);

        $display("[TB] start and zero-wait fetch");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_req", imem_req, 1);
        applyStimulus(16'h1A00, 0, 8'd0, 3'b101, 8'd1);

        $display("[TB] five wait states");
        applyStimulus(16'h0C00, 5, 8'd1, 3'b110, 8'd2);

        $display("[TB] branches");
        applyStimulus(16'hF007, 0, 8'd2, 3'b000, 8'd10);
        znc = 3'b100;
        applyStimulus(16'hF804, 0, 8'd10, 3'b000, 8'd15);
        znc = 3'b011;
        applyStimulus(16'hF804, 0, 8'd15, 3'b000, 8'd16);
        applyStimulus(16'hF0F9, 0, 8'd16, 3'b000, 8'd10);
        applyStimulus(16'hF804, 0, 8'd10, 3'b000, 8'd11);
        applyStimulus(16'hF202, 0, 8'd11, 3'b000, 8'd14);
        applyStimulus(16'hF0F2, 0, 8'd14, 3'b000, 8'd1);
        applyStimulus(16'hF0FC, 0, 8'd1, 3'b000, 8'd254);

        $display("[TB] nop and pc wrap");
        applyStimulus(16'h0000, 0, 8'd254, 3'b000, 8'd255);
        applyStimulus(16'h0000, 0, 8'd255, 3'b000, 8'd0);
        applyStimulus(16'h0000, 0, 8'd0, 3'b000, 8'd1);

        $display("[TB] halt and restart");
        applyStimulus(16'hE000, 0, 8'd1, 3'b000, 8'd1);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_busy", busy, 0);
        checkOutput("halt_req", imem_req, 0);
        imem_ack  = 1'b1;
        imem_data = 16'h1A00;
        @(negedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("halt_hold_pc", pc, 8'd1);
        checkOutput("halt_hold_op", opCode, 16'hE000);
        checkOutput("halt_hold_en", {a_en, b_en, znc_en}, 3'b000);
        checkOutput("halt_hold_halted", halted, 1);
        start = 1'b1;
        @(negedge clk);
        checkOutput("restart_pc", pc, 8'd0);
        checkOutput("restart_req", imem_req, 1);
        checkOutput("restart_halted", halted, 0);
        applyStimulus(16'hE000, 0, 8'd0, 3'b000, 8'd0);
        checkOutput("halt2_halted", halted, 1);
        @(negedge clk);
        checkOutput("held_start_req", imem_req, 1);
        checkOutput("held_start_halted", halted, 0);
        start = 1'b0;

        $display("[TB] reset during fetch");
        applyStimulus(16'h0000, 0, 8'd0, 3'b000, 8'd1);
        checkOutput("pre_rst_req", imem_req, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req", imem_req, 0);
        checkOutput("async_rst_pc", pc, 8'd0);
        checkOutput("async_rst_busy", busy, 0);
        imem_ack  = 1'b1;
        imem_data = 16'h1A00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_op", opCode, 16'h0000);
        checkOutput("late_ack_en", {a_en, b_en, znc_en}, 3'b000);
        checkOutput("late_ack_req", imem_req, 0);
        checkOutput("late_ack_busy", busy, 0);
        imem_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_en", {a_en, b_en, znc_en}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
